input_buffer_ctrl: RTL and testbench

//   Sequencer for the systolic-array input (A-operand) buffer bank.

---
 rtl/input_buffer_ctrl_pkg.sv | 17 +
 rtl/input_buffer_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_input_buffer_ctrl.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_buffer_ctrl_pkg.sv
// Config constants and shared types for the systolic-array A-operand buffer sequencer.
package input_buffer_ctrl_pkg;

   localparam int SYS_ROWS           = 4;
   localparam int A_BITWIDTH         = 8;
   localparam int INPUT_BUFFER_DEPTH = 16;
   localparam int INBUF_AW           = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_ARR,
      STREAM,
      DRAIN
   } inbuf_state_e;

endpackage

// File: rtl/input_buffer_ctrl.sv
// Input buffer sequencer: loads k_len A columns into all row FIFOs, then streams and drains them.
// Optional start-to-done cycle counter enabled by defining INBUF_CTRL_PERF_EN.
module input_buffer_ctrl
   import input_buffer_ctrl_pkg::*;
#(
   parameter int  ROWS   = SYS_ROWS,
   parameter int  DWIDTH = A_BITWIDTH,
   parameter int  DEPTH  = INPUT_BUFFER_DEPTH,
   parameter int  AW     = INBUF_AW,
   localparam int KW     = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [KW-1:0]            k_len,
   input  logic [AW-1:0]            base_addr,
   input  logic                     array_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     mem_req,
   output logic [AW-1:0]            mem_addr,
   input  logic                     mem_gnt,
   input  logic                     mem_rvalid,
   input  logic [ROWS*DWIDTH-1:0]   mem_rdata,
   output logic [ROWS-1:0]          buf_wr_en,
   output logic [ROWS*DWIDTH-1:0]   buf_wr_data,
   output logic                     buf_read,
   output logic [31:0]              perf_cycles
);

   localparam int DRW = $clog2(ROWS + 1);

   inbuf_state_e            state_q, state_d;
   logic [KW-1:0]           k_len_q, k_len_d;
   logic [AW-1:0]           base_q, base_d;
   logic [KW-1:0]           issued_q, issued_d;
   logic [KW-1:0]           recvd_q, recvd_d;
   logic [KW-1:0]           stream_cnt_q, stream_cnt_d;
   logic [DRW-1:0]          drain_cnt_q, drain_cnt_d;
   logic [ROWS-1:0]         wr_en_q, wr_en_d;
   logic [ROWS*DWIDTH-1:0]  wr_data_q, wr_data_d;
   logic                    err_q, err_d;

   logic k_len_ok;
   logic start_accept;
   logic rvalid_accept;

   assign k_len_ok      = (k_len != '0) && (int'(k_len) <= DEPTH);
   assign start_accept  = (state_q == IDLE) && start && k_len_ok;
   assign rvalid_accept = (state_q == LOAD) && mem_rvalid && (recvd_q < k_len_q);

   assign busy        = (state_q != IDLE);
   assign mem_req     = (state_q == LOAD) && (issued_q < k_len_q);
   assign mem_addr    = base_q + AW'(issued_q);
   assign buf_read    = (state_q == STREAM);
   assign done        = (state_q == DRAIN) && (drain_cnt_q == DRW'(ROWS - 1));
   assign err         = err_q;
   assign buf_wr_en   = wr_en_q;
   assign buf_wr_data = wr_data_q;

   always_comb begin
      state_d      = state_q;
      k_len_d      = k_len_q;
      base_d       = base_q;
      issued_d     = issued_q;
      recvd_d      = recvd_q;
      stream_cnt_d = stream_cnt_q;
      drain_cnt_d  = drain_cnt_q;
      wr_en_d      = '0;
      wr_data_d    = wr_data_q;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_accept) begin
               k_len_d  = k_len;
               base_d   = base_addr;
               issued_d = '0;
               recvd_d  = '0;
               state_d  = LOAD;
            end else if (start) begin
               err_d = 1'b1;
            end
         end

         LOAD: begin
            if (mem_req && mem_gnt) begin
               issued_d = issued_q + KW'(1);
            end
            // Returns beyond k_len are dropped so a full-depth tile cannot overflow the FIFOs.
            if (rvalid_accept) begin
               wr_en_d   = '1;
               wr_data_d = mem_rdata;
               recvd_d   = recvd_q + KW'(1);
            end
            if (recvd_q == k_len_q) begin
               state_d = WAIT_ARR;
            end
         end

         WAIT_ARR: begin
            if (array_ready) begin
               stream_cnt_d = '0;
               state_d      = STREAM;
            end
         end

         STREAM: begin
            if (stream_cnt_q == k_len_q - KW'(1)) begin
               drain_cnt_d = '0;
               state_d     = DRAIN;
            end else begin
               stream_cnt_d = stream_cnt_q + KW'(1);
            end
         end

         DRAIN: begin
            // ROWS-1 cycles of row skew plus one cycle of FIFO read latency.
            if (drain_cnt_q == DRW'(ROWS - 1)) begin
               state_d = IDLE;
            end else begin
               drain_cnt_d = drain_cnt_q + DRW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         k_len_q      <= '0;
         base_q       <= '0;
         issued_q     <= '0;
         recvd_q      <= '0;
         stream_cnt_q <= '0;
         drain_cnt_q  <= '0;
         wr_en_q      <= '0;
         wr_data_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         k_len_q      <= k_len_d;
         base_q       <= base_d;
         issued_q     <= issued_d;
         recvd_q      <= recvd_d;
         stream_cnt_q <= stream_cnt_d;
         drain_cnt_q  <= drain_cnt_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         err_q        <= err_d;
      end
   end

`ifdef INBUF_CTRL_PERF_EN
   logic [31:0] perf_q, perf_d;

   // Cleared on an accepted start, counts every busy cycle, then holds until the next tile.
   always_comb begin
      perf_d = perf_q;
      if (start_accept) begin
         perf_d = '0;
      end else if (state_q != IDLE) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Randomized self-checking bench for input_buffer_ctrl against a queue-based tile model.
// Checks perf_cycles against start-to-done distance when INBUF_CTRL_PERF_EN is defined.
module tb_input_buffer_ctrl;

   localparam int ROWS   = 4;
   localparam int DWIDTH = 8;
   localparam int DEPTH  = 16;
   localparam int AW     = 16;
   localparam int KW     = 5;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [KW-1:0]          k_len;
   logic [AW-1:0]          base_addr;
   logic                   array_ready;
   logic                   busy;
   logic                   done;
   logic                   err;
   logic                   mem_req;
   logic [AW-1:0]          mem_addr;
   logic                   mem_gnt;
   logic                   mem_rvalid;
   logic [ROWS*DWIDTH-1:0] mem_rdata;
   logic [ROWS-1:0]        buf_wr_en;
   logic [ROWS*DWIDTH-1:0] buf_wr_data;
   logic                   buf_read;
   logic [31:0]            perf_cycles;

   input_buffer_ctrl #(
      .ROWS   (ROWS),
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .k_len       (k_len),
      .base_addr   (base_addr),
      .array_ready (array_ready),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .buf_wr_en   (buf_wr_en),
      .buf_wr_data (buf_wr_data),
      .buf_read    (buf_read),
      .perf_cycles (perf_cycles)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // Observed activity, reset at the start of each scenario.
   logic [AW-1:0]          addr_q[$];
   logic [ROWS*DWIDTH-1:0] wr_q[$];
   int                     rd_q[$];
   int                     done_q[$];
   int                     err_cnt, req_cnt, wr_partial, occ, max_occ;

   // Memory responder knobs.
   int gnt_pct = 100;
   int lat_min = 2;
   int lat_max = 2;
   int gap_pct = 0;
   bit stray_rv = 1'b0;

   typedef struct {
      logic [AW-1:0] addr;
      int            due;
   } pend_t;
   pend_t pend[$];

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      return {lo + 8'd3, lo ^ 8'h5A, a[15:8] + lo, ~lo};
   endfunction

   task automatic clear_mon();
      addr_q.delete();
      wr_q.delete();
      rd_q.delete();
      done_q.delete();
      err_cnt    = 0;
      req_cnt    = 0;
      wr_partial = 0;
      occ        = 0;
      max_occ    = 0;
   endtask

   // In-order memory model: grant at random, return data lat_min..lat_max cycles later with random gaps.
   initial begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         if (rst === 1'b1) begin
            pend.delete();
            mem_gnt = 1'b0;
         end else begin
            if (stray_rv) begin
               mem_rvalid = 1'b1;
               stray_rv   = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc && int'($urandom_range(99)) >= gap_pct) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_word(pend[0].addr);
               void'(pend.pop_front());
            end
            mem_gnt = (int'($urandom_range(99)) < gnt_pct);
            #1;
            if (mem_req === 1'b1 && mem_gnt) begin
               addr_q.push_back(mem_addr);
               pend.push_back('{mem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (buf_wr_en !== '0) begin
            if (buf_wr_en !== '1) wr_partial++;
            wr_q.push_back(buf_wr_data);
            occ++;
         end
         if (buf_read === 1'b1) begin
            rd_q.push_back(cyc);
            occ--;
         end
         if (occ > max_occ) max_occ = occ;
         if (done === 1'b1) done_q.push_back(cyc);
         if (err === 1'b1) err_cnt++;
         if (mem_req === 1'b1) req_cnt++;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish, required finish before 50000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic run_tile(input int k, input logic [AW-1:0] base, input int hold, input bit poke);
      int t;
      int start_cyc;
      int ready_cyc;
      int exp_i;
      logic [AW-1:0] ea;
      ready_cyc = 0;
      clear_mon();
      @(negedge clk);
      start     = 1'b1;
      k_len     = KW'(k);
      base_addr = base;
      start_cyc = cyc;
      if (hold > 0) array_ready = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      k_len     = KW'($urandom);
      base_addr = AW'($urandom);
      if (poke) begin
         repeat (2) @(negedge clk);
         start     = 1'b1;
         k_len     = 5'd3;
         base_addr = 16'h7777;
         @(negedge clk);
         start = 1'b0;
      end
      if (hold > 0) begin
         t = 0;
         while (wr_q.size() < k && t < 2000) begin
            @(negedge clk);
            #3;
            t++;
         end
         tests++;
         if (wr_q.size() < k) begin
            fails++;
            $display("[TB] FAIL load_timeout: got %0d writes, required %0d", wr_q.size(), k);
         end
         stray_rv = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #3;
            tests++;
            if (busy !== 1'b1 || buf_read !== 1'b0) begin
               fails++;
               $display("[TB] FAIL wait_hold: got busy=%b buf_read=%b, required busy=1 buf_read=0", busy, buf_read);
            end
         end
         array_ready = 1'b1;
         ready_cyc   = cyc;
      end
      t = 0;
      while (done_q.size() == 0 && t < 3000) begin
         @(negedge clk);
         #3;
         t++;
      end
      tests++;
      if (done_q.size() == 0) begin
         fails++;
         $display("[TB] FAIL done_timeout: got no done, required done within 3000 cycles");
      end
      @(negedge clk);
      #3;
      tests++;
`ifdef INBUF_CTRL_PERF_EN
      exp_i = (done_q.size() > 0) ? done_q[0] - start_cyc : -1;
      if (perf_cycles !== 32'(exp_i)) begin
         fails++;
         $display("[TB] FAIL perf_cycles: got %0d, required %0d", perf_cycles, exp_i);
      end
`else
      if (perf_cycles !== 32'd0) begin
         fails++;
         $display("[TB] FAIL perf_cycles: got %0d, required 0", perf_cycles);
      end
`endif
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL busy_after_done: got %b, required 0", busy);
      end
      repeat (3) @(negedge clk);
      #3;

      tests++;
      if (addr_q.size() != k) begin
         fails++;
         $display("[TB] FAIL addr_count: got %0d, required %0d", addr_q.size(), k);
      end
      tests++;
      for (int i = 0; i < addr_q.size(); i++) begin
         ea = base + AW'(i);
         if (addr_q[i] !== ea) begin
            fails++;
            $display("[TB] FAIL addr_order: beat %0d got %h, required %h", i, addr_q[i], ea);
            break;
         end
      end
      tests++;
      if (wr_q.size() != k) begin
         fails++;
         $display("[TB] FAIL write_count: got %0d, required %0d", wr_q.size(), k);
      end
      tests++;
      for (int i = 0; i < wr_q.size(); i++) begin
         ea = base + AW'(i);
         if (wr_q[i] !== mem_word(ea)) begin
            fails++;
            $display("[TB] FAIL write_data: beat %0d got %h, required %h", i, wr_q[i], mem_word(ea));
            break;
         end
      end
      tests++;
      if (wr_partial != 0) begin
         fails++;
         $display("[TB] FAIL write_all_rows: got %0d partial enables, required 0", wr_partial);
      end
      tests++;
      if (rd_q.size() != k) begin
         fails++;
         $display("[TB] FAIL read_count: got %0d, required %0d", rd_q.size(), k);
      end
      tests++;
      for (int i = 0; i < rd_q.size(); i++) begin
         if (rd_q[i] != rd_q[0] + i) begin
            fails++;
            $display("[TB] FAIL read_contiguous: read %0d at cycle %0d, required %0d", i, rd_q[i], rd_q[0] + i);
            break;
         end
      end
      tests++;
      if (done_q.size() != 1) begin
         fails++;
         $display("[TB] FAIL done_count: got %0d, required 1", done_q.size());
      end
      tests++;
      exp_i = (rd_q.size() > 0) ? rd_q[rd_q.size() - 1] + ROWS : -1;
      if (done_q.size() == 0 || done_q[0] != exp_i) begin
         fails++;
         $display("[TB] FAIL done_timing: got cycle %0d, required %0d", (done_q.size() > 0) ? done_q[0] : -1, exp_i);
      end
      tests++;
      if (max_occ > DEPTH) begin
         fails++;
         $display("[TB] FAIL fifo_occupancy: got %0d, required <= %0d", max_occ, DEPTH);
      end
      if (hold > 0) begin
         tests++;
         exp_i = ready_cyc + 1;
         if (rd_q.size() == 0 || rd_q[0] != exp_i) begin
            fails++;
            $display("[TB] FAIL stream_after_ready: got cycle %0d, required %0d", (rd_q.size() > 0) ? rd_q[0] : -1, exp_i);
         end
      end
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      start       = 1'b0;
      k_len       = '0;
      base_addr   = '0;
      array_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      tests++;
      if ({busy, done, err, mem_req, buf_wr_en, buf_read} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_outputs: got %b, required all zero", {busy, done, err, mem_req, buf_wr_en, buf_read});
      end
      tests++;
      if (perf_cycles !== 32'd0) begin
         fails++;
         $display("[TB] FAIL reset_perf: got %0d, required 0", perf_cycles);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      gnt_pct = 100; lat_min = 2; lat_max = 2; gap_pct = 0;
      run_tile(5, 16'h0100, 0, 1'b0);
   endtask

   task automatic test_array_wait();
      run_tile(7, 16'h0200, 10, 1'b0);
   endtask

   task automatic test_illegal_klen();
      int vals[3];
      vals[0] = 0;
      vals[1] = 17;
      vals[2] = int'($urandom_range(31, 17));
      foreach (vals[j]) begin
         clear_mon();
         @(negedge clk);
         start = 1'b1;
         k_len = KW'(vals[j]);
         @(negedge clk);
         start = 1'b0;
         #3;
         tests++;
         if (err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_err: k_len=%0d got err=%b busy=%b, required err=1 busy=0", vals[j], err, busy);
         end
         @(negedge clk);
         #3;
         tests++;
         if (err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_pulse_width: k_len=%0d got err=%b, required 0", vals[j], err);
         end
         repeat (2) @(negedge clk);
         #3;
         tests++;
         if (req_cnt != 0 || busy !== 1'b0 || wr_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL illegal_quiet: k_len=%0d got req=%0d busy=%b writes=%0d, required 0/0/0",
                     vals[j], req_cnt, busy, wr_q.size());
         end
      end
   endtask

   task automatic test_random_full();
      gnt_pct = 50; lat_min = 2; lat_max = 5; gap_pct = 30;
      run_tile(16, AW'($urandom), 0, 1'b0);
      run_tile(8, 16'hFFFC, 0, 1'b0);
      for (int n = 0; n < 5; n++) begin
         run_tile(int'($urandom_range(16, 1)), AW'($urandom), 0, 1'b0);
      end
      gnt_pct = 100; lat_min = 2; lat_max = 2; gap_pct = 0;
   endtask

   task automatic test_reset_mid();
      int t;
      clear_mon();
      @(negedge clk);
      start     = 1'b1;
      k_len     = 5'd8;
      base_addr = 16'h0300;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (buf_read !== 1'b1 && t < 2000) begin
         @(negedge clk);
         #3;
         t++;
      end
      tests++;
      if (buf_read !== 1'b1) begin
         fails++;
         $display("[TB] FAIL stream_reach: got buf_read=%b, required 1", buf_read);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #3;
      tests++;
      if ({busy, done, err, mem_req, buf_wr_en, buf_read} !== '0) begin
         fails++;
         $display("[TB] FAIL midreset_outputs: got %b, required all zero", {busy, done, err, mem_req, buf_wr_en, buf_read});
      end
      tests++;
      if (perf_cycles !== 32'd0) begin
         fails++;
         $display("[TB] FAIL midreset_perf: got %0d, required 0", perf_cycles);
      end
      rst = 1'b0;
      run_tile(6, 16'h0400, 0, 1'b0);
   endtask

   task automatic test_back_to_back_busy();
      clear_mon();
      stray_rv = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      tests++;
      if (wr_q.size() != 0 || busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL stray_rvalid: got writes=%0d busy=%b, required 0/0", wr_q.size(), busy);
      end
      run_tile(6, 16'h0500, 0, 1'b1);
      repeat (4) @(negedge clk);
      #3;
      tests++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         fails++;
         $display("[TB] FAIL start_while_busy: got busy=%b mem_req=%b, required 0/0", busy, mem_req);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_array_wait();
      test_illegal_klen();
      test_random_full();
      test_reset_mid();
      test_back_to_back_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
